// File: rtl/sram_trace_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_trace_monitor_pkg
// Description : Shared types and entry layout helpers for the SRAM trace monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_trace_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // SRAM_WE_N level that marks a write cycle
    localparam logic c_WE_N_ACTIVE = 1'b0;

    // Entry layout, LSB first: data, addr, we, ts
    function automatic int off_addr(input int cap_w);
        return cap_w;
    endfunction

    function automatic int off_we(input int cap_w, input int addr_w);
        return cap_w + addr_w;
    endfunction

    function automatic int off_ts(input int cap_w, input int addr_w);
        return cap_w + addr_w + 1;
    endfunction

    function automatic int entry_w(input int ts_w, input int addr_w, input int cap_w);
        return ts_w + 1 + addr_w + cap_w;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_trace_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_trace_monitor_if
// Description : Tapped SRAM bus, capture controls and readout of the monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_trace_monitor_if
    import sram_trace_monitor_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 64,
    parameter int CAP_W  = 32,
    parameter int DEPTH  = 64,
    parameter int TS_W   = 16
);
    localparam int c_CNT_W = cnt_w(DEPTH);
    localparam int c_RD_W  = entry_w(TS_W, ADDR_W, CAP_W);

    logic                SRAM_WE_N;
    logic [ADDR_W-1:0]   SRAM_ADDR;
    logic [DATA_W-1:0]   SRAM_DQ;
    logic [ADDR_W-1:0]   win_lo;
    logic [ADDR_W-1:0]   win_hi;
    logic                cap_rd;
    logic [ADDR_W-1:0]   trig_addr;
    logic                trig_we;
    logic [c_CNT_W-1:0]  post_cnt;
    logic                arm;
    logic                rd_en;
    logic [c_RD_W-1:0]   rd_data;
    logic                rd_valid;
    logic [c_CNT_W-1:0]  count;
    logic                wrapped;
    logic [1:0]          state;

    modport master (
        output SRAM_WE_N, SRAM_ADDR, SRAM_DQ, win_lo, win_hi, cap_rd,
               trig_addr, trig_we, post_cnt, arm, rd_en,
        input  rd_data, rd_valid, count, wrapped, state
    );

    modport slave (
        input  SRAM_WE_N, SRAM_ADDR, SRAM_DQ, win_lo, win_hi, cap_rd,
               trig_addr, trig_we, post_cnt, arm, rd_en,
        output rd_data, rd_valid, count, wrapped, state
    );
endinterface
`default_nettype wire

// File: rtl/sram_trace_monitor_ram.sv
`default_nettype none
// ============================================================================
// Module      : sram_trace_monitor_ram
// Description : DEPTH x WIDTH trace store, one write port, one registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_trace_monitor_ram
    import sram_trace_monitor_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 66
) (
    input  wire logic                     clk,
    input  wire logic                     i_we,
    input  wire logic [$clog2(DEPTH)-1:0] i_waddr,
    input  wire logic [WIDTH-1:0]         i_wdata,
    input  wire logic                     i_re,
    input  wire logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic      [WIDTH-1:0]         o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_q;
endmodule
`default_nettype wire

// File: rtl/sram_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : sram_trace_monitor
// Description : Passive SRAM bus tap with filtered, triggered circular trace.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_trace_monitor
    import sram_trace_monitor_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 64,
    parameter int CAP_W  = 32,
    parameter int DEPTH  = 64,
    parameter int TS_W   = 16
) (
    input wire logic          clk,
    input wire logic          rst,
    sram_trace_monitor_if.slave bus
);
    localparam int c_CNT_W   = cnt_w(DEPTH);
    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_ENTRY_W = entry_w(TS_W, ADDR_W, CAP_W);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [ADDR_W-1:0]    r_prev_addr;
    logic                 r_prev_we_n;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [TS_W-1:0]      r_ts;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   r_remaining;
    logic                 r_wrapped;
    logic                 r_rd_valid;

    logic                 w_we_bit;
    logic                 w_addr_chg;
    logic                 w_evt;
    logic                 w_in_win;
    logic                 w_capturing;
    logic                 w_store;
    logic                 w_trig;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_enter_done;
    logic                 w_wrapped_nxt;
    logic [c_PTR_W-1:0]   w_wr_ptr_nxt;
    logic [c_CNT_W-1:0]   w_post;
    logic [c_ENTRY_W-1:0] w_entry;
    logic [c_ENTRY_W-1:0] w_ram_q;
    logic                 w_dq_unused;

    assign w_we_bit    = (bus.SRAM_WE_N == c_WE_N_ACTIVE);
    assign w_addr_chg  = (bus.SRAM_ADDR != r_prev_addr);
    assign w_evt       = w_we_bit ? (r_prev_we_n || w_addr_chg)
                                  : (bus.cap_rd && (w_addr_chg || !r_prev_we_n));
    assign w_in_win    = (bus.win_lo <= bus.SRAM_ADDR) && (bus.SRAM_ADDR <= bus.win_hi);
    assign w_capturing = (r_state == ST_ARMED) || (r_state == ST_POST);
    // arm wins over a coincident event
    assign w_store     = w_capturing && w_evt && w_in_win && !bus.arm;
    assign w_trig      = (r_state == ST_ARMED) && w_store
                      && (bus.SRAM_ADDR == bus.trig_addr) && (w_we_bit == bus.trig_we);
    assign w_full      = (r_count == c_CNT_W'(DEPTH));
    assign w_post      = (bus.post_cnt > c_CNT_W'(DEPTH - 1)) ? c_CNT_W'(DEPTH - 1) : bus.post_cnt;
    assign w_pop       = (r_state == ST_DONE) && bus.rd_en && (r_count != '0) && !bus.arm;

    assign w_wr_ptr_nxt  = w_store ? r_wr_ptr + c_PTR_W'(1) : r_wr_ptr;
    assign w_wrapped_nxt = r_wrapped || (w_store && w_full);
    assign w_enter_done  = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
    assign w_entry       = {r_ts, w_we_bit, bus.SRAM_ADDR, bus.SRAM_DQ[CAP_W-1:0]};
    assign w_dq_unused   = ^bus.SRAM_DQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.arm) begin
            w_state_nxt = ST_ARMED;
        end else begin
            case (r_state)
                ST_ARMED: if (w_trig) w_state_nxt = (w_post == '0) ? ST_DONE : ST_POST;
                ST_POST:  if (w_store && r_remaining == c_CNT_W'(1)) w_state_nxt = ST_DONE;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_addr <= '0;
            r_prev_we_n <= 1'b1;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ts        <= '0;
            r_count     <= '0;
            r_remaining <= '0;
            r_wrapped   <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_prev_addr <= bus.SRAM_ADDR;
            r_prev_we_n <= bus.SRAM_WE_N;
            r_rd_valid  <= w_pop;
            if (bus.arm) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_ts        <= '0;
                r_count     <= '0;
                r_remaining <= '0;
                r_wrapped   <= 1'b0;
            end else begin
                if (w_capturing) begin
                    r_ts <= r_ts + TS_W'(1);
                end
                if (w_store) begin
                    r_wr_ptr  <= w_wr_ptr_nxt;
                    r_wrapped <= w_wrapped_nxt;
                    if (!w_full) begin
                        r_count <= r_count + c_CNT_W'(1);
                    end
                end else if (w_pop) begin
                    r_count  <= r_count - c_CNT_W'(1);
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                if (w_trig) begin
                    r_remaining <= w_post;
                end else if (r_state == ST_POST && w_store) begin
                    r_remaining <= r_remaining - c_CNT_W'(1);
                end
                // After a wrap the slot about to be overwritten holds the oldest entry
                if (w_enter_done) begin
                    r_rd_ptr <= w_wrapped_nxt ? w_wr_ptr_nxt : '0;
                end
            end
        end
    end

    sram_trace_monitor_ram #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_store),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_entry),
        .i_re    (w_pop),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_q)
    );

    assign bus.rd_data  = r_rd_valid ? w_ram_q : '0;
    assign bus.rd_valid = r_rd_valid;
    assign bus.count    = r_count;
    assign bus.wrapped  = r_wrapped;
    assign bus.state    = r_state;
endmodule
`default_nettype wire

// File: tb/tb_sram_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_trace_monitor
// Description : Directed + random stimulus against a queue-based trace model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_trace_monitor;
    import sram_trace_monitor_pkg::*;

    localparam int c_ADDR_W  = 17;
    localparam int c_DATA_W  = 64;
    localparam int c_CAP_W   = 32;
    localparam int c_DEPTH   = 64;
    localparam int c_TS_W    = 16;
    localparam int c_ENTRY_W = entry_w(c_TS_W, c_ADDR_W, c_CAP_W);

    typedef struct {
        logic [c_ENTRY_W-1:0] data;
        int                   due;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [c_ENTRY_W-1:0] m_trace[$];
    exp_t                 exp_q[$];
    exp_t                 mon_e;
    int                   m_phase;
    int                   m_left_post;
    logic                 m_wrapped;
    logic [c_TS_W-1:0]    m_ts;
    logic [c_ADDR_W-1:0]  m_prev_addr;
    logic                 m_prev_we_n;

    sram_trace_monitor_if #(
        .ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W), .CAP_W(c_CAP_W), .DEPTH(c_DEPTH), .TS_W(c_TS_W)
    ) bus ();

    sram_trace_monitor #(
        .ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W), .CAP_W(c_CAP_W), .DEPTH(c_DEPTH), .TS_W(c_TS_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_trace.delete();
        exp_q.delete();
        m_phase     = 0;
        m_left_post = 0;
        m_wrapped   = 1'b0;
        m_ts        = '0;
        m_prev_addr = '0;
        m_prev_we_n = 1'b1;
    endtask

    // Applies the rules to the inputs currently driven, as of the next rising edge
    task automatic model_step();
        logic                we;
        logic [c_ADDR_W-1:0] a;
        logic                evt;
        logic                kept;
        exp_t                e;
        we   = !bus.SRAM_WE_N;
        a    = bus.SRAM_ADDR;
        evt  = we ? (m_prev_we_n || a != m_prev_addr)
                  : (bus.cap_rd && (a != m_prev_addr || !m_prev_we_n));
        kept = evt && (bus.win_lo <= a) && (a <= bus.win_hi);
        if (bus.arm) begin
            m_trace.delete();
            m_wrapped = 1'b0;
            m_ts      = '0;
            m_phase   = 1;
        end else if (m_phase == 1 || m_phase == 2) begin
            if (kept) begin
                if (m_trace.size() == c_DEPTH) begin
                    void'(m_trace.pop_front());
                    m_wrapped = 1'b1;
                end
                m_trace.push_back({m_ts, we, a, bus.SRAM_DQ[c_CAP_W-1:0]});
                if (m_phase == 1 && a == bus.trig_addr && we == bus.trig_we) begin
                    m_left_post = (int'(bus.post_cnt) > c_DEPTH - 1) ? c_DEPTH - 1 : int'(bus.post_cnt);
                    m_phase     = (m_left_post == 0) ? 3 : 2;
                end else if (m_phase == 2) begin
                    m_left_post--;
                    if (m_left_post == 0) m_phase = 3;
                end
            end
            m_ts = m_ts + 1'b1;
        end else if (m_phase == 3 && bus.rd_en && m_trace.size() > 0) begin
            e.data = m_trace.pop_front();
            e.due  = cyc + 1;
            exp_q.push_back(e);
        end
        m_prev_we_n = bus.SRAM_WE_N;
        m_prev_addr = a;
    endtask

    task automatic check_outputs();
        chk("state", bus.state, m_phase);
        chk("count", bus.count, m_trace.size());
        chk("wrapped", bus.wrapped, m_wrapped);
    endtask

    // Called at a falling edge; holds the given inputs for one cycle
    task automatic step(input logic we_n, input logic [c_ADDR_W-1:0] a, input logic rd, input logic am);
        check_outputs();
        bus.SRAM_WE_N = we_n;
        bus.SRAM_ADDR = a;
        bus.SRAM_DQ   = {$urandom(), $urandom()};
        bus.rd_en     = rd;
        bus.arm       = am;
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, bus.SRAM_ADDR, 1'b0, 1'b0);
    endtask

    task automatic cfg(input logic [c_ADDR_W-1:0] lo, input logic [c_ADDR_W-1:0] hi, input logic cap,
                       input logic [c_ADDR_W-1:0] ta, input logic tw, input int pc);
        bus.win_lo    = lo;
        bus.win_hi    = hi;
        bus.cap_rd    = cap;
        bus.trig_addr = ta;
        bus.trig_we   = tw;
        bus.post_cnt  = 7'(pc);
    endtask

    task automatic drain();
        int g = 0;
        while (m_trace.size() > 0 && g < 400) begin
            step(1'b1, bus.SRAM_ADDR, 1'($urandom_range(0, 1)), 1'b0);
            g++;
        end
        step(1'b1, bus.SRAM_ADDR, 1'b1, 1'b0);
        idle(2);
    endtask

    // Scoreboard consumer: every rd_valid must match the oldest expected entry on time
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rd_valid_unexpected", bus.rd_valid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rd_data", bus.rd_data, mon_e.data);
                    chk("rd_latency", cyc, mon_e.due);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                chk("rd_valid_missing", bus.rd_valid, 1'b1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.SRAM_WE_N = 1'b1;
        bus.SRAM_ADDR = '0;
        bus.SRAM_DQ   = '0;
        bus.rd_en     = 1'b0;
        bus.arm       = 1'b0;
        cfg(17'h0, 17'h1FFFF, 1'b0, 17'h0, 1'b1, 0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_state", bus.state, 2'd0);
        chk("reset_count", bus.count, 0);
        chk("reset_rd_valid", bus.rd_valid, 1'b0);
        chk("reset_rd_data", bus.rd_data, 0);
        rst = 1'b0;
        idle(2);

        // Three writes, trigger on the last one
        cfg(17'h0, 17'h1FFFF, 1'b0, 17'h00102, 1'b1, 0);
        step(1'b1, bus.SRAM_ADDR, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 17'h00100 + 17'(i), 1'b0, 1'b0);
        chk("t1_state", bus.state, 2'd3);
        chk("t1_count", bus.count, 3);
        drain();

        // Reads filtered by cap_rd, then included
        cfg(17'h0, 17'h1FFFF, 1'b0, 17'h00014, 1'b0, 0);
        step(1'b1, bus.SRAM_ADDR, 1'b0, 1'b1);
        step(1'b1, 17'h00010, 1'b0, 1'b0);
        step(1'b0, 17'h00020, 1'b0, 1'b0);
        step(1'b1, 17'h00014, 1'b0, 1'b0);
        chk("t2_count_wronly", bus.count, 1);
        bus.cap_rd = 1'b1;
        step(1'b1, bus.SRAM_ADDR, 1'b0, 1'b1);
        step(1'b1, 17'h00010, 1'b0, 1'b0);
        step(1'b0, 17'h00020, 1'b0, 1'b0);
        step(1'b1, 17'h00014, 1'b0, 1'b0);
        chk("t2_count_rdwr", bus.count, 3);
        drain();

        // Overflow: 100 writes into 64 slots
        cfg(17'h0, 17'h1FFFF, 1'b0, 17'd99, 1'b1, 0);
        step(1'b1, bus.SRAM_ADDR, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) step(1'b0, 17'(i), 1'b0, 1'b0);
        chk("t3_count", bus.count, 64);
        chk("t3_wrapped", bus.wrapped, 1'b1);
        drain();

        // Post-trigger window of five entries
        cfg(17'h0, 17'h1FFFF, 1'b0, 17'h00050, 1'b1, 5);
        step(1'b1, bus.SRAM_ADDR, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) step(1'b0, 17'h00040 + 17'(i), 1'b0, 1'b0);
        chk("t4_count", bus.count, 22);
        drain();

        // Address window and held write
        cfg(17'h00100, 17'h001FF, 1'b0, 17'h1FFFF, 1'b1, 0);
        step(1'b1, bus.SRAM_ADDR, 1'b0, 1'b1);
        step(1'b0, 17'h000FF, 1'b0, 1'b0);
        step(1'b0, 17'h00100, 1'b0, 1'b0);
        step(1'b0, 17'h00200, 1'b0, 1'b0);
        chk("t5_window", bus.count, 1);
        for (int i = 0; i < 4; i++) step(1'b0, 17'h00150, 1'b0, 1'b0);
        chk("t5_hold", bus.count, 2);

        // Re-arm mid-POST (arm beats a coincident write), then async reset
        cfg(17'h0, 17'h1FFFF, 1'b0, 17'h00010, 1'b1, 10);
        step(1'b1, bus.SRAM_ADDR, 1'b0, 1'b1);
        step(1'b0, 17'h00010, 1'b0, 1'b0);
        step(1'b0, 17'h00011, 1'b0, 1'b0);
        chk("t6_post", bus.state, 2'd2);
        step(1'b0, 17'h00012, 1'b0, 1'b1);
        chk("t6_rearm_state", bus.state, 2'd1);
        chk("t6_rearm_count", bus.count, 0);
        step(1'b0, 17'h00013, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_state", bus.state, 2'd0);
        chk("t6_rst_count", bus.count, 0);
        chk("t6_rst_wrapped", bus.wrapped, 1'b0);
        chk("t6_rst_rd_valid", bus.rd_valid, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Randomised sessions
        for (int run = 0; run < 40; run++) begin
            cfg(17'($urandom_range(0, 15)), 17'($urandom_range(8, 31)), 1'($urandom_range(0, 1)),
                17'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom_range(0, 80));
            step(1'b1, bus.SRAM_ADDR, 1'b0, 1'b1);
            for (int k = 0; k < 250 && m_phase != 3; k++) begin
                step(1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? bus.SRAM_ADDR : 17'($urandom_range(0, 31)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0));
            end
            if (m_phase == 3) begin
                if ($urandom_range(0, 4) == 0) begin
                    step(1'b1, bus.SRAM_ADDR, 1'b1, 1'b0);
                    step(1'b1, bus.SRAM_ADDR, 1'b1, 1'b1);
                end
                drain();
            end
        end

        idle(3);
        check_outputs();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
